// File: rtl/imem_access_arbiter_pkg.sv
// Shared definitions for the instruction-memory access arbiter: load encodings,
// the fetch substitute for missing memory, state encoding and load helpers.
package imem_access_arbiter_pkg;

  localparam logic [2:0]  LB  = 3'b000;
  localparam logic [2:0]  LH  = 3'b001;
  localparam logic [2:0]  LW  = 3'b010;
  localparam logic [2:0]  LBU = 3'b100;
  localparam logic [2:0]  LHU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    LD_SECOND = 2'd2,
    LD_MERGE  = 2'd3
  } state_t;

  function automatic logic ld_type_valid(input logic [2:0] t);
    return (t == LB) || (t == LH) || (t == LW) || (t == LBU) || (t == LHU);
  endfunction

  // A load crosses a word boundary when its bytes spill into the next word.
  function automatic logic ld_crosses(input logic [2:0] t, input logic [1:0] off);
    return (((t == LH) || (t == LHU)) && (off == 2'd3)) || ((t == LW) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/imem_access_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter, bundled for port lists.
interface imem_access_arbiter_if #(
  parameter int MEM_ADDR_W = 9
);
  logic                  fetch_req;
  logic [31:0]           fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_rvalid;
  logic [31:0]           fetch_rdata;
  logic                  ld_req;
  logic [31:0]           ld_addr;
  logic [2:0]            ld_type;
  logic                  ld_gnt;
  logic                  ld_rvalid;
  logic [31:0]           ld_rdata;
  logic                  mem_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_addr, ld_type, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_rvalid, ld_rdata,
           mem_en, mem_addr
  );

  modport master (
    output fetch_req, fetch_addr, ld_req, ld_addr, ld_type, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_rvalid, ld_rdata,
           mem_en, mem_addr
  );
endinterface

// File: rtl/imem_access_arbiter_load_align_extend.sv
// Selects the addressed bytes from one word (or a word pair for crossing loads)
// and sign/zero-extends them to 32 bits.
module load_align_extend
  import imem_access_arbiter_pkg::*;
(
  input  logic [31:0] cur_i,
  input  logic [31:0] next_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  ld_type_i,
  input  logic        crossing_i,
  output logic [31:0] result_o
);
  logic [63:0] pair;
  logic [63:0] shifted;
  logic [5:0]  shamt;
  logic [31:0] sel;

  always_comb begin
    pair  = {(crossing_i ? next_i : 32'h0), cur_i};
    shamt = {off_i, 3'b000};
    // A non-crossing halfword is picked by addr[1] alone; a crossing one starts at byte 3.
    if (ld_type_i[1:0] == 2'b01) begin
      shamt = crossing_i ? 6'd24 : {1'b0, off_i[1], 4'b0000};
    end
    shifted = pair >> shamt;
    sel     = shifted[31:0];
    unique case (ld_type_i)
      LB:      result_o = {{24{sel[7]}}, sel[7:0]};
      LH:      result_o = {{16{sel[15]}}, sel[15:0]};
      LW:      result_o = sel;
      LBU:     result_o = {24'h0, sel[7:0]};
      LHU:     result_o = {16'h0, sel[15:0]};
      default: result_o = 32'h0;
    endcase
  end
endmodule

// File: rtl/imem_access_arbiter.sv
// Shares one synchronous-read instruction RAM between fetch and loads; loads
// crossing a word boundary take two back-to-back reads and a merge cycle.
module imem_access_arbiter
  import imem_access_arbiter_pkg::*;
#(
  parameter int MEM_SIZE   = 512,
  parameter int MEM_ADDR_W = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_access_arbiter_if.slave  bus
);
  localparam int          SW         = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);

  state_t                state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [31:0]           hold_q, hold_d;
  logic                  resp_ld_q, resp_ld_d;
  logic                  zero_q, zero_d;
  logic                  fetch_oob_q, fetch_oob_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            type_q, type_d;
  logic [MEM_ADDR_W-1:0] next_idx_q, next_idx_d;
  logic                  next_oob_q, next_oob_d;
  logic [31:0]           fetch_rdata_q, ld_rdata_q;

  logic        accept, fetch_wins, crossing;
  logic        fetch_gnt, ld_gnt, fetch_rvalid, ld_rvalid, mem_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0] fetch_data_c, ld_data_c, align_out, cur_word, next_word;
  logic [31:0] f_idx, l_idx, l_next_idx;
  logic        f_oob, l_oob;
  logic        unused_bits;

  // Indices kept at full width so addresses past the RAM never alias low words.
  assign f_idx       = {2'b00, bus.fetch_addr[31:2]};
  assign l_idx       = {2'b00, bus.ld_addr[31:2]};
  assign l_next_idx  = l_idx + 32'd1;
  assign f_oob       = (f_idx >= MEM_SIZE_W);
  assign l_oob       = (l_idx >= MEM_SIZE_W);
  assign unused_bits = ^bus.fetch_addr[1:0];

  assign cur_word  = (state_q == LD_MERGE) ? hold_q : bus.mem_rdata;
  assign next_word = next_oob_q ? 32'h0 : bus.mem_rdata;

  load_align_extend u_align (
    .cur_i      (cur_word),
    .next_i     (next_word),
    .off_i      (off_q),
    .ld_type_i  (type_q),
    .crossing_i (state_q == LD_MERGE),
    .result_o   (align_out)
  );

  always_comb begin
    state_d      = IDLE;
    starve_d     = starve_q;
    hold_d       = hold_q;
    resp_ld_d    = resp_ld_q;
    zero_d       = zero_q;
    fetch_oob_d  = fetch_oob_q;
    off_d        = off_q;
    type_d       = type_q;
    next_idx_d   = next_idx_q;
    next_oob_d   = next_oob_q;
    accept       = 1'b0;
    fetch_wins   = 1'b0;
    crossing     = 1'b0;
    fetch_gnt    = 1'b0;
    ld_gnt       = 1'b0;
    fetch_rvalid = 1'b0;
    ld_rvalid    = 1'b0;
    mem_en       = 1'b0;
    mem_addr     = '0;
    fetch_data_c = fetch_oob_q ? NOP_INSTR : bus.mem_rdata;
    ld_data_c    = zero_q ? 32'h0 : align_out;

    unique case (state_q)
      IDLE: accept = 1'b1;
      RESP: begin
        accept = 1'b1;
        if (resp_ld_q) ld_rvalid = 1'b1;
        else           fetch_rvalid = 1'b1;
      end
      LD_SECOND: begin
        hold_d   = bus.mem_rdata;
        mem_en   = !next_oob_q;
        mem_addr = next_idx_q;
        state_d  = LD_MERGE;
      end
      LD_MERGE: ld_rvalid = 1'b1;
      default: ;
    endcase

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    if (accept && rst_n) begin
      fetch_wins = bus.fetch_req && (!bus.ld_req || (starve_q == STARVE_LIM));
      if (fetch_wins) begin
        fetch_gnt   = 1'b1;
        starve_d    = '0;
        resp_ld_d   = 1'b0;
        fetch_oob_d = f_oob;
        mem_en      = !f_oob;
        mem_addr    = f_idx[MEM_ADDR_W-1:0];
        state_d     = RESP;
      end else if (bus.ld_req) begin
        ld_gnt     = 1'b1;
        crossing   = ld_type_valid(bus.ld_type) && ld_crosses(bus.ld_type, bus.ld_addr[1:0]);
        resp_ld_d  = 1'b1;
        zero_d     = !ld_type_valid(bus.ld_type) || l_oob;
        off_d      = bus.ld_addr[1:0];
        type_d     = bus.ld_type;
        next_idx_d = l_next_idx[MEM_ADDR_W-1:0];
        next_oob_d = (l_next_idx >= MEM_SIZE_W);
        mem_en     = ld_type_valid(bus.ld_type) && !l_oob;
        mem_addr   = l_idx[MEM_ADDR_W-1:0];
        state_d    = crossing ? LD_SECOND : RESP;
        if (bus.fetch_req) starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      hold_q        <= '0;
      resp_ld_q     <= 1'b0;
      zero_q        <= 1'b0;
      fetch_oob_q   <= 1'b0;
      off_q         <= '0;
      type_q        <= '0;
      next_idx_q    <= '0;
      next_oob_q    <= 1'b0;
      fetch_rdata_q <= '0;
      ld_rdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      hold_q      <= hold_d;
      resp_ld_q   <= resp_ld_d;
      zero_q      <= zero_d;
      fetch_oob_q <= fetch_oob_d;
      off_q       <= off_d;
      type_q      <= type_d;
      next_idx_q  <= next_idx_d;
      next_oob_q  <= next_oob_d;
      if (fetch_rvalid) fetch_rdata_q <= fetch_data_c;
      if (ld_rvalid)    ld_rdata_q    <= ld_data_c;
    end
  end

  assign bus.fetch_gnt    = fetch_gnt;
  assign bus.ld_gnt       = ld_gnt;
  assign bus.fetch_rvalid = fetch_rvalid;
  assign bus.ld_rvalid    = ld_rvalid;
  assign bus.mem_en       = mem_en;
  assign bus.mem_addr     = mem_addr;
  assign bus.fetch_rdata  = fetch_rvalid ? fetch_data_c : fetch_rdata_q;
  assign bus.ld_rdata     = ld_rvalid ? ld_data_c : ld_rdata_q;
endmodule

// File: tb/tb_imem_access_arbiter.sv
// Self-checking bench: directed plan cases plus randomized single accesses
// compared against a byte-level memory model.
module tb_imem_access_arbiter;
  import imem_access_arbiter_pkg::*;

  localparam int MEM_SIZE   = 512;
  localparam int MEM_ADDR_W = 9;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem [MEM_SIZE];

  imem_access_arbiter_if #(.MEM_ADDR_W(MEM_ADDR_W)) bus ();

  imem_access_arbiter #(
    .MEM_SIZE(MEM_SIZE), .MEM_ADDR_W(MEM_ADDR_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    if ((a >> 2) >= 32'(MEM_SIZE)) return 8'h00;
    w = mem[a[MEM_ADDR_W+1:2]];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  function automatic int ld_size(input logic [2:0] t);
    case (t)
      LB, LBU: return 1;
      LH, LHU: return 2;
      LW:      return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a);
    int n;
    logic [31:0] base, v;
    n = ld_size(t);
    if (n == 0) return 32'h0;
    if ((a >> 2) >= 32'(MEM_SIZE)) return 32'h0;
    base = a;
    if (n == 2 && (int'(a[1:0]) + n <= 4)) base[0] = 1'b0;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(byte_at(base + 32'(i))) << (8 * i));
    if (t == LB) v = {{24{v[7]}}, v[7:0]};
    if (t == LH) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic int model_ld_lat(input logic [2:0] t, input logic [31:0] a);
    int n;
    n = ld_size(t);
    return (n != 0 && (int'(a[1:0]) + n > 4)) ? 2 : 1;
  endfunction

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    if ((a >> 2) >= 32'(MEM_SIZE)) return NOP_INSTR;
    return mem[a[MEM_ADDR_W+1:2]];
  endfunction

  // Issues one request, waits for its grant and response; reports what it saw.
  task automatic do_access(input bit is_ld, input logic [31:0] a, input logic [2:0] t,
                           output logic [31:0] d, output int lat, output logic en_at_gnt);
    int w;
    logic g;
    d = 32'h0; lat = -1; en_at_gnt = 1'b0;
    @(posedge clk); #1;
    if (is_ld) begin bus.ld_req = 1'b1; bus.ld_addr = a; bus.ld_type = t; end
    else begin bus.fetch_req = 1'b1; bus.fetch_addr = a; end
    w = 0;
    @(negedge clk); #1;
    g = is_ld ? bus.ld_gnt : bus.fetch_gnt;
    while (!g && w < 20) begin
      @(negedge clk); #1; w++;
      g = is_ld ? bus.ld_gnt : bus.fetch_gnt;
    end
    if (g) en_at_gnt = bus.mem_en;
    @(posedge clk); #1;
    bus.ld_req = 1'b0; bus.fetch_req = 1'b0;
    if (!g) return;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
      if (is_ld ? bus.ld_rvalid : bus.fetch_rvalid) begin
        lat = i;
        d = is_ld ? bus.ld_rdata : bus.fetch_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.fetch_req = 1'b1; bus.ld_req = 1'b1;
    bus.fetch_addr = 32'h0; bus.ld_addr = 32'h0; bus.ld_type = LW;
    #2;
    checks++;
    if ({bus.fetch_gnt, bus.ld_gnt, bus.fetch_rvalid, bus.ld_rvalid, bus.mem_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {bus.fetch_gnt, bus.ld_gnt, bus.fetch_rvalid, bus.ld_rvalid, bus.mem_en});
    end
    checks++;
    if ({bus.fetch_rdata, bus.ld_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h want=0/0", bus.fetch_rdata, bus.ld_rdata);
    end
    bus.fetch_req = 1'b0; bus.ld_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({bus.fetch_rvalid, bus.ld_rvalid, bus.mem_en} !== 3'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b want=000", {bus.fetch_rvalid, bus.ld_rvalid, bus.mem_en});
    end
  endtask

  task automatic test_directed();
    logic [2:0]  typ  [5] = '{LB, LBU, LH, LHU, 3'b011};
    logic [31:0] adr  [5] = '{32'h3, 32'h7, 32'h2, 32'h1, 32'h0};
    logic [31:0] want [5] = '{32'h11, 32'hAA, 32'h1122, 32'h3344, 32'h0};
    logic [31:0] d;
    int lat;
    logic en;
    do_access(1'b0, 32'h4, 3'b0, d, lat, en);
    checks++;
    if (d !== 32'hAABBCCDD || lat != 1) begin
      failures++;
      $display("FAIL fetch_basic got=%h lat=%0d want=aabbccdd lat=1", d, lat);
    end
    for (int i = 0; i < 5; i++) begin
      do_access(1'b1, adr[i], typ[i], d, lat, en);
      checks++;
      if (d !== want[i] || lat != 1 || en !== (typ[i] != 3'b011)) begin
        failures++;
        $display("FAIL load_dir%0d got=%h lat=%0d en=%b want=%h lat=1", i, d, lat, en, want[i]);
      end
    end
    do_access(1'b1, 32'h2, LH, d, lat, en);
    @(negedge clk); #1;
    checks++;
    if (bus.ld_rvalid !== 1'b0 || bus.ld_rdata !== 32'h1122) begin
      failures++;
      $display("FAIL rdata_hold got=%h rv=%b want=00001122 rv=0", bus.ld_rdata, bus.ld_rvalid);
    end
  endtask

  task automatic test_crossing();
    logic [31:0] d;
    int lat;
    logic en;
    @(posedge clk); #1;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h1; bus.ld_type = LW;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
    @(negedge clk); #1;
    checks++;
    if ({bus.fetch_gnt, bus.ld_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL cross_gnt got=%b want=01", {bus.fetch_gnt, bus.ld_gnt});
    end
    @(posedge clk); #1;
    bus.ld_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({bus.fetch_gnt, bus.ld_gnt, bus.ld_rvalid, bus.mem_en} !== 4'b0001 || bus.mem_addr !== 9'd1) begin
      failures++;
      $display("FAIL cross_second got=%b addr=%0d want=0001 addr=1",
               {bus.fetch_gnt, bus.ld_gnt, bus.ld_rvalid, bus.mem_en}, bus.mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.fetch_gnt, bus.ld_gnt, bus.ld_rvalid} !== 3'b001 || bus.ld_rdata !== 32'hDD112233) begin
      failures++;
      $display("FAIL cross_merge got=%b data=%h want=001 dd112233",
               {bus.fetch_gnt, bus.ld_gnt, bus.ld_rvalid}, bus.ld_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.fetch_gnt !== 1'b1) begin
      failures++;
      $display("FAIL cross_fetch_after got=%b want=1", bus.fetch_gnt);
    end
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 32'h11223344) begin
      failures++;
      $display("FAIL cross_fetch_data got=%h rv=%b want=11223344", bus.fetch_rdata, bus.fetch_rvalid);
    end
    do_access(1'b1, 32'h3, LHU, d, lat, en);
    checks++;
    if (d !== 32'h0000DD11 || lat != 2) begin
      failures++;
      $display("FAIL cross_lhu got=%h lat=%0d want=0000dd11 lat=2", d, lat);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] fa, la, d;
    logic [1:0]  win_prev, win;
    int cnt, lat;
    logic en;
    fa = 32'($urandom_range(0, MEM_SIZE - 1)) << 2;
    la = 32'($urandom_range(0, MEM_SIZE - 1)) << 2;
    do_access(1'b0, fa, 3'b0, d, lat, en);
    cnt = 0;
    win_prev = 2'b00;
    @(posedge clk); #1;
    bus.fetch_req = 1'b1; bus.fetch_addr = fa;
    bus.ld_req = 1'b1; bus.ld_addr = la; bus.ld_type = LW;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk); #1;
      if (k >= 1) begin
        checks++;
        if ({bus.fetch_rvalid, bus.ld_rvalid} !== win_prev ||
            (win_prev[1] && bus.fetch_rdata !== mem[fa[MEM_ADDR_W+1:2]]) ||
            (win_prev[0] && bus.ld_rdata !== mem[la[MEM_ADDR_W+1:2]])) begin
          failures++;
          $display("FAIL starve_rvalid k=%0d got=%b f=%h l=%h want=%b", k,
                   {bus.fetch_rvalid, bus.ld_rvalid}, bus.fetch_rdata, bus.ld_rdata, win_prev);
        end
      end
      if (k < 10) begin
        if (cnt == STARVE_MAX) begin win = 2'b10; cnt = 0; end
        else begin win = 2'b01; cnt++; end
        checks++;
        if ({bus.fetch_gnt, bus.ld_gnt} !== win) begin
          failures++;
          $display("FAIL starve_gnt k=%0d got=%b want=%b", k, {bus.fetch_gnt, bus.ld_gnt}, win);
        end
        win_prev = win;
      end
      if (k == 9) begin
        @(posedge clk); #1;
        bus.fetch_req = 1'b0; bus.ld_req = 1'b0;
      end
    end
  endtask

  task automatic test_oob();
    logic [31:0] d, a;
    int lat;
    logic en;
    do_access(1'b0, 32'(MEM_SIZE) * 4, 3'b0, d, lat, en);
    checks++;
    if (d !== NOP_INSTR || lat != 1 || en !== 1'b0) begin
      failures++;
      $display("FAIL oob_fetch got=%h lat=%0d en=%b want=00000013 lat=1 en=0", d, lat, en);
    end
    a = 32'(MEM_SIZE - 1) * 4 + 2;
    do_access(1'b1, a, LW, d, lat, en);
    checks++;
    if (d !== {16'h0, mem[MEM_SIZE-1][31:16]} || lat != 2) begin
      failures++;
      $display("FAIL oob_lw_cross got=%h lat=%0d want=%h lat=2", d, lat, {16'h0, mem[MEM_SIZE-1][31:16]});
    end
    do_access(1'b1, 32'(MEM_SIZE) * 4 + 1, LB, d, lat, en);
    checks++;
    if (d !== 32'h0 || lat != 1 || en !== 1'b0) begin
      failures++;
      $display("FAIL oob_lb got=%h lat=%0d en=%b want=0 lat=1 en=0", d, lat, en);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, want;
    logic [2:0]  t;
    int lat, want_lat;
    logic en;
    bit is_ld;
    for (int n = 0; n < 40; n++) begin
      is_ld = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, MEM_SIZE * 4 + 15));
      t = 3'($urandom_range(0, 7));
      want     = is_ld ? model_load(t, a) : model_fetch(a);
      want_lat = is_ld ? model_ld_lat(t, a) : 1;
      do_access(is_ld, a, t, d, lat, en);
      $display("txn %0d ld=%0d type=%0d addr=%h data=%h lat=%0d", n, is_ld, t, a, d, lat);
      checks++;
      if (d !== want || lat != want_lat) begin
        failures++;
        $display("FAIL rand%0d got=%h lat=%0d want=%h lat=%0d", n, d, lat, want, want_lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int lat;
    logic en, stray;
    @(posedge clk); #1;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h1; bus.ld_type = LW;
    @(negedge clk); #1;
    checks++;
    if (bus.ld_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_gnt got=%b want=1", bus.ld_gnt);
    end
    @(posedge clk); #1;
    bus.ld_req = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.fetch_gnt, bus.ld_gnt, bus.fetch_rvalid, bus.ld_rvalid, bus.mem_en} !== 5'b0 ||
        {bus.fetch_rdata, bus.ld_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b f=%h l=%h want=00000 0 0",
               {bus.fetch_gnt, bus.ld_gnt, bus.fetch_rvalid, bus.ld_rvalid, bus.mem_en},
               bus.fetch_rdata, bus.ld_rdata);
    end
    bus.fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      stray = stray | bus.ld_rvalid | bus.fetch_rvalid;
    end
    checks++;
    if (stray !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_stale got=%b want=0", stray);
    end
    do_access(1'b0, 32'h4, 3'b0, d, lat, en);
    checks++;
    if (d !== 32'hAABBCCDD || lat != 1) begin
      failures++;
      $display("FAIL rstmid_fetch got=%h lat=%0d want=aabbccdd lat=1", d, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = $urandom;
    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
    bus.mem_rdata = 32'h0;
    bus.fetch_req = 1'b0; bus.fetch_addr = 32'h0;
    bus.ld_req = 1'b0; bus.ld_addr = 32'h0; bus.ld_type = LB;
    test_reset();
    test_directed();
    test_crossing();
    test_starvation();
    test_oob();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
